// File: rtl/coder_pkg.sv
// coder_pkg: shared definitions for the Coder sequencer.
//   - seq_state_e : sequencer states (IDLE, FEED, DRAIN, DONE)
//   - CODER_N_DEF : default word width
//   - code_to_bit : maps one 2-bit Coder code back to its data bit
//                   (00 -> 1, anything else -> 0); benches may use it too.
package coder_pkg;

  localparam int CODER_N_DEF = 23;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

  function automatic logic code_to_bit(input logic [1:0] code);
    return (code == 2'b00);
  endfunction

endpackage

// File: rtl/code_capture.sv
// code_capture: collects the codes returned by Coder into the packed code word.
// The payload enable is delayed by CODER_LAT cycles so that it lines up with
// code_i. Each aligned cycle writes code_i into slot cap_cnt and advances
// cap_cnt. The counter saturates at N and is cleared when a new word is accepted.
//
// Optional build macro: CODER_SEQ_CHECK_EN adds a decode register and the
// dec_nxt_o port. dec_nxt_o is the decoded word including the write of the
// current cycle.
//
// Ports:
//   clk_i, rstn_i  clock, synchronous active-low reset
//   clr_i          new word accepted; clears cap_cnt
//   bit_en_i       bit_o carries a payload bit this cycle
//   code_i         Coder.code_o
//   code_word_o    packed codes; slot k = [2k+1:2k]
//   dec_nxt_o      decoded word (CODER_SEQ_CHECK_EN only)
module code_capture
  import coder_pkg::*;
#(
  parameter int N         = CODER_N_DEF,
  parameter int CODER_LAT = 1
) (
  input  logic           clk_i,
  input  logic           rstn_i,
  input  logic           clr_i,
  input  logic           bit_en_i,
  input  logic [1:0]     code_i,
  output logic [2*N-1:0] code_word_o
`ifdef CODER_SEQ_CHECK_EN
  ,
  output logic [N-1:0]   dec_nxt_o
`endif
);

  localparam int CW = $clog2(N + 1);

  logic [CODER_LAT-1:0] en_dly_q;
  logic [CW-1:0]        cap_cnt_q;
  logic                 cap_we;

  // The counter saturates at N, so stray enables can never overrun the word.
  assign cap_we = en_dly_q[CODER_LAT-1] && (cap_cnt_q != CW'(N));

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      en_dly_q    <= '0;
      cap_cnt_q   <= '0;
      code_word_o <= '0;
    end else begin
      en_dly_q <= (en_dly_q << 1) | CODER_LAT'(bit_en_i);
      if (clr_i) begin
        cap_cnt_q <= '0;
      end else if (cap_we) begin
        cap_cnt_q <= cap_cnt_q + CW'(1);
      end
      for (int k = 0; k < N; k++) begin
        if (cap_we && (cap_cnt_q == CW'(k))) begin
          code_word_o[2*k +: 2] <= code_i;
        end
      end
    end
  end

`ifdef CODER_SEQ_CHECK_EN
  logic [N-1:0] dec_q;

  always_comb begin
    dec_nxt_o = dec_q;
    for (int k = 0; k < N; k++) begin
      if (cap_we && (cap_cnt_q == CW'(k))) begin
        dec_nxt_o[k] = code_to_bit(code_i);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      dec_q <= '0;
    end else begin
      dec_q <= dec_nxt_o;
    end
  end
`endif

endmodule

// File: rtl/coder_seq_ctrl.sv
// coder_seq_ctrl: word-level sequencer for the serial Coder block.
// It accepts an N-bit word through valid/ready and shifts the word into Coder
// LSB first, one bit per clock. It waits CODER_LAT cycles for the last code and
// then holds the packed 2N-bit code word until ack_i.
//
// Optional build macro: CODER_SEQ_CHECK_EN adds err_o. err_o is set on entry
// to DONE when the decoded codes differ from the word that was sent, and it is
// cleared by the ack.
//
// Ports:
//   clk_i, rstn_i        clock, synchronous active-low reset
//   data_i/valid_i       word input, ready_o accepts
//   bit_o, bit_en_o      serial bit to Coder and payload flag
//   code_i               Coder.code_o
//   code_word_o, done_o  result and completion, ack_i releases
//   err_o                self-check mismatch (CODER_SEQ_CHECK_EN only)
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | ready for a word
// FEED  | shifting N bits into Coder
// DRAIN | waiting CODER_LAT cycles for the last codes
// DONE  | code word complete and held until ack_i
module coder_seq_ctrl
  import coder_pkg::*;
#(
  parameter int N         = CODER_N_DEF,
  parameter int CODER_LAT = 1
) (
  input  logic           clk_i,
  input  logic           rstn_i,
  input  logic [N-1:0]   data_i,
  input  logic           valid_i,
  output logic           ready_o,
  output logic           bit_o,
  output logic           bit_en_o,
  input  logic [1:0]     code_i,
  output logic [2*N-1:0] code_word_o,
  output logic           done_o,
  input  logic           ack_i
`ifdef CODER_SEQ_CHECK_EN
  ,
  output logic           err_o
`endif
);

  localparam int CW = $clog2(N + 1);

  seq_state_e    state_q, state_d;
  logic [N-1:0]  shreg_q;
  logic [CW-1:0] bit_cnt_q;
  logic          accept;
  logic          ready_d, bit_en_d, done_d;

  // ready_o is a flop that reset clears, so the first accept can only
  // happen after one clock with reset released.
  assign accept = (state_q == IDLE) && valid_i && ready_o;

  // The shift register is empty once the word has gone out, so bit_o is
  // low outside FEED without any extra gating.
  assign bit_o = shreg_q[0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = FEED;
      FEED:    if (bit_cnt_q == CW'(N - 1)) state_d = DRAIN;
      DRAIN:   if (bit_cnt_q == CW'(CODER_LAT - 1)) state_d = DONE;
      DONE:    if (ack_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d  = (state_d == IDLE);
    bit_en_d = (state_d == FEED);
    done_d   = (state_d == DONE);
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      ready_o   <= 1'b0;
      bit_en_o  <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ready_o  <= ready_d;
      bit_en_o <= bit_en_d;
      done_o   <= done_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            shreg_q   <= data_i;
            bit_cnt_q <= '0;
          end
        end
        FEED: begin
          shreg_q <= shreg_q >> 1;
          // The bit counter is reused to time DRAIN, so it restarts here.
          if (state_d == DRAIN) bit_cnt_q <= '0;
          else                  bit_cnt_q <= bit_cnt_q + CW'(1);
        end
        DRAIN: begin
          if (state_d == DRAIN) bit_cnt_q <= bit_cnt_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef CODER_SEQ_CHECK_EN
  logic [N-1:0] dec_nxt;
  logic [N-1:0] word_q;
`endif

  code_capture #(
    .N         (N),
    .CODER_LAT (CODER_LAT)
  ) u_capture (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .clr_i       (accept),
    .bit_en_i    (bit_en_o),
    .code_i      (code_i),
    .code_word_o (code_word_o)
`ifdef CODER_SEQ_CHECK_EN
    ,
    .dec_nxt_o   (dec_nxt)
`endif
  );

`ifdef CODER_SEQ_CHECK_EN
  // The shift register is consumed during FEED, so a copy of the word is kept
  // for the comparison. dec_nxt already contains the final slot that is
  // written on the DRAIN->DONE edge.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      word_q <= '0;
      err_o  <= 1'b0;
    end else begin
      if (accept) word_q <= data_i;
      if (state_q == DONE && ack_i) begin
        err_o <= 1'b0;
      end else if (state_q == DRAIN && state_d == DONE) begin
        err_o <= (dec_nxt != word_q);
      end
    end
  end
`endif

endmodule

// File: tb/tb_coder_seq_ctrl.sv
// Testbench for coder_seq_ctrl. It uses two instances: the default
// configuration (N=23, CODER_LAT=1) and a short configuration (N=8, CODER_LAT=3).
// Each instance talks to a behavioural Coder model. The reference code word is
// built from the data bits with plain per-bit arithmetic.
module tb_coder_seq_ctrl;

  localparam int NA = 23, LA = 1;
  localparam int NB = 8,  LB = 3;

  logic CLK_tb = 1'b0;
  always #5 CLK_tb = ~CLK_tb;

  logic        rstn_tb;
  logic        sel;
  logic        valid_tb, ack_tb;
  logic [63:0] data_tb;
  int          coder_mode;
  int          n_checks, n_err;

  logic            ready_a, bit_a, en_a, done_a;
  logic [1:0]      code_a;
  logic [2*NA-1:0] word_a;
  logic            ready_b, bit_b, en_b, done_b;
  logic [1:0]      code_b;
  logic [2*NB-1:0] word_b;
`ifdef CODER_SEQ_CHECK_EN
  logic err_a, err_b;
`endif

  coder_seq_ctrl #(.N(NA), .CODER_LAT(LA)) dut_a (
    .clk_i(CLK_tb), .rstn_i(rstn_tb), .data_i(data_tb[NA-1:0]),
    .valid_i(valid_tb & ~sel), .ready_o(ready_a), .bit_o(bit_a), .bit_en_o(en_a),
    .code_i(code_a), .code_word_o(word_a), .done_o(done_a), .ack_i(ack_tb & ~sel)
`ifdef CODER_SEQ_CHECK_EN
    , .err_o(err_a)
`endif
  );

  coder_seq_ctrl #(.N(NB), .CODER_LAT(LB)) dut_b (
    .clk_i(CLK_tb), .rstn_i(rstn_tb), .data_i(data_tb[NB-1:0]),
    .valid_i(valid_tb & sel), .ready_o(ready_b), .bit_o(bit_b), .bit_en_o(en_b),
    .code_i(code_b), .code_word_o(word_b), .done_o(done_b), .ack_i(ack_tb & sel)
`ifdef CODER_SEQ_CHECK_EN
    , .err_o(err_b)
`endif
  );

  // Coder model. A 1 bit encodes as 00. A 0 bit encodes as a nonzero code that
  // depends on the mode. Mode 1 is a faulty coder that returns 00 for every bit.
  function automatic logic [1:0] code_of(input logic b, input int mode);
    if (mode == 1) return 2'b00;
    if (b) return 2'b00;
    return (mode == 2) ? 2'b11 : 2'b10;
  endfunction

  logic [1:0] pa [0:LA-1];
  logic [1:0] pb [0:LB-1];
  always @(posedge CLK_tb) begin
    pa[0] <= code_of(bit_a, coder_mode);
    for (int i = 1; i < LA; i++) pa[i] <= pa[i-1];
    pb[0] <= code_of(bit_b, coder_mode);
    for (int i = 1; i < LB; i++) pb[i] <= pb[i-1];
  end
  assign code_a = pa[LA-1];
  assign code_b = pb[LB-1];

  // Observation mux for the selected instance.
  logic        obs_ready, obs_bit, obs_en, obs_done, obs_err;
  logic [45:0] obs_word;
  always_comb begin
    obs_err = 1'b0;
    if (sel) begin
      obs_ready = ready_b; obs_bit = bit_b; obs_en = en_b; obs_done = done_b;
      obs_word  = {30'b0, word_b};
`ifdef CODER_SEQ_CHECK_EN
      obs_err = err_b;
`endif
    end else begin
      obs_ready = ready_a; obs_bit = bit_a; obs_en = en_a; obs_done = done_a;
      obs_word  = word_a;
`ifdef CODER_SEQ_CHECK_EN
      obs_err = err_a;
`endif
    end
  end

  function automatic logic [45:0] exp_word(input logic [63:0] d, input int n, input int mode);
    logic [45:0] w = '0;
    for (int k = 0; k < n; k++) w[2*k +: 2] = code_of(d[k], mode);
    return w;
  endfunction

  task automatic tick();
    @(posedge CLK_tb);
    #1;
  endtask

  task automatic accept_word(input logic [63:0] d);
    int w = 0;
    while (!obs_ready && w < 60) begin tick(); w++; end
    n_checks++;
    if (obs_ready !== 1'b1) begin
      n_err++;
      $display("FAIL accept_wait: ready_o=%b after %0d cycles, required 1", obs_ready, w);
    end
    data_tb = d; valid_tb = 1'b1;
    tick();
    valid_tb = 1'b0;
  endtask

  task automatic ack_word();
    ack_tb = 1'b1;
    tick();
    ack_tb = 1'b0;
  endtask

  // Starts in the cycle right after the accept edge. It checks the serial
  // stream, the drain gap, the done latency and the captured code word.
  task automatic feed_word(input logic [63:0] d, input int n, input int lat, input int mode,
                           input string tag);
    logic [63:0] seen, mask;
    logic        feed_bad, drain_bad;
    logic [45:0] exp;
    int          c;
    seen = '0; feed_bad = 1'b0; drain_bad = 1'b0;
    mask = (64'd1 << n) - 64'd1;
    for (int k = 0; k < n; k++) begin
      seen[k] = obs_bit;
      if (obs_en !== 1'b1 || obs_done !== 1'b0 || obs_ready !== 1'b0) feed_bad = 1'b1;
      tick();
    end
    c = n;
    while (obs_done !== 1'b1 && c < n + lat + 20) begin
      if (obs_en !== 1'b0 || obs_bit !== 1'b0) drain_bad = 1'b1;
      tick(); c++;
    end
    n_checks++;
    if ((seen & mask) !== (d & mask)) begin
      n_err++;
      $display("FAIL %s bit_stream: got %h, required %h", tag, seen & mask, d & mask);
    end
    n_checks++;
    if (feed_bad !== 1'b0) begin
      n_err++;
      $display("FAIL %s feed_flags: bit_en/done/ready wrong during FEED, got bad=%b required 0", tag, feed_bad);
    end
    n_checks++;
    if (drain_bad !== 1'b0) begin
      n_err++;
      $display("FAIL %s drain_quiet: bit_en/bit_o active during DRAIN, got bad=%b required 0", tag, drain_bad);
    end
    n_checks++;
    if (c != n + lat || obs_done !== 1'b1) begin
      n_err++;
      $display("FAIL %s done_latency: got %0d cycles (done=%b), required %0d", tag, c, obs_done, n + lat);
    end
    exp = exp_word(d, n, mode);
    n_checks++;
    if (obs_word !== exp) begin
      n_err++;
      $display("FAIL %s code_word: got %h, required %h", tag, obs_word, exp);
    end
`ifdef CODER_SEQ_CHECK_EN
    begin
      logic [63:0] dec;
      dec = '0;
      for (int k = 0; k < n; k++) dec[k] = (code_of(d[k], mode) == 2'b00);
      n_checks++;
      if (obs_err !== (dec != (d & mask))) begin
        n_err++;
        $display("FAIL %s err_o: got %b, required %b", tag, obs_err, dec != (d & mask));
      end
    end
`endif
  endtask

  task automatic test_reset();
    logic bad;
    rstn_tb = 1'b0; valid_tb = 1'b0; ack_tb = 1'b0; data_tb = '0; sel = 1'b0; coder_mode = 0;
    repeat (3) tick();
    n_checks++;
    if (ready_a !== 1'b0 || done_a !== 1'b0 || en_a !== 1'b0 || bit_a !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: ready=%b done=%b en=%b bit=%b, required all 0", ready_a, done_a, en_a, bit_a);
    end
    n_checks++;
    if (word_a !== '0 || word_b !== '0) begin
      n_err++;
      $display("FAIL reset_word: got %h/%h, required 0", word_a, word_b);
    end
`ifdef CODER_SEQ_CHECK_EN
    n_checks++;
    if (err_a !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b, required 0", err_a); end
`endif
    rstn_tb = 1'b1;
    tick();
    n_checks++;
    if (ready_a !== 1'b1 || ready_b !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release_ready: got %b/%b, required 1", ready_a, ready_b);
    end
    bad = 1'b0;
    repeat (50) begin
      if (ready_a !== 1'b1 || done_a !== 1'b0 || en_a !== 1'b0 || word_a !== '0) bad = 1'b1;
      tick();
    end
    n_checks++;
    if (bad !== 1'b0) begin n_err++; $display("FAIL idle_50: got bad=%b, required 0", bad); end
  endtask

  task automatic test_known_word();
    logic [22:0] dec;
    sel = 1'b0; coder_mode = 0;
    accept_word(64'd8201481);
    feed_word(64'd8201481, NA, LA, 0, "known");
    for (int k = 0; k < NA; k++) dec[k] = (obs_word[2*k +: 2] == 2'b00);
    n_checks++;
    if (dec !== 23'd8201481) begin
      n_err++;
      $display("FAIL known_decode: got %0d, required 8201481", dec);
    end
    ack_word();
  endtask

  task automatic test_faulty_coder();
    sel = 1'b0; coder_mode = 1;
    accept_word(64'd0);
    feed_word(64'd0, NA, LA, 1, "allzero_w0");
    ack_word();
    accept_word(64'h7FFFFF);
    feed_word(64'h7FFFFF, NA, LA, 1, "allzero_wff");
    ack_word();
    coder_mode = 0;
  endtask

  task automatic test_random();
    logic [63:0] d;
    int m;
    for (int i = 0; i < 6; i++) begin
      sel = (i >= 4);
      d = {$urandom, $urandom};
      m = $urandom_range(0, 2);
      coder_mode = m;
      accept_word(d);
      feed_word(d, sel ? NB : NA, sel ? LB : LA, m, sel ? "rand_b" : "rand_a");
      ack_word();
    end
    sel = 1'b0; coder_mode = 0;
  endtask

  task automatic test_ack_hold();
    logic [63:0] w1, w2;
    logic [45:0] held;
    logic bad;
    sel = 1'b0; coder_mode = 0;
    w1 = {41'b0, 23'($urandom)};
    w2 = {41'b0, 23'($urandom)};
    accept_word(w1);
    feed_word(w1, NA, LA, 0, "hold_w1");
    held = exp_word(w1, NA, 0);
    data_tb = w2; valid_tb = 1'b1;
    bad = 1'b0;
    repeat (10) begin
      tick();
      if (obs_done !== 1'b1 || obs_ready !== 1'b0 || obs_en !== 1'b0 || obs_word !== held) bad = 1'b1;
    end
    n_checks++;
    if (bad !== 1'b0) begin n_err++; $display("FAIL hold_stable: got bad=%b, required 0", bad); end
    ack_tb = 1'b1;
    tick();
    ack_tb = 1'b0;
    n_checks++;
    if (obs_ready !== 1'b1 || obs_done !== 1'b0 || obs_en !== 1'b0) begin
      n_err++;
      $display("FAIL hold_after_ack: ready=%b done=%b en=%b, required 1/0/0", obs_ready, obs_done, obs_en);
    end
    tick();
    valid_tb = 1'b0;
    n_checks++;
    if (obs_en !== 1'b1 || obs_ready !== 1'b0) begin
      n_err++;
      $display("FAIL hold_next_accept: en=%b ready=%b, required 1/0", obs_en, obs_ready);
    end
    feed_word(w2, NA, LA, 0, "hold_w2");
    ack_word();
  endtask

  task automatic test_back_to_back();
    int cnt, w;
    logic prev;
    sel = 1'b0; coder_mode = 0;
    data_tb = 64'h155555; valid_tb = 1'b1; ack_tb = 1'b1;
    w = 0;
    do begin tick(); w++; end while (obs_en !== 1'b1 && w < 60);
    data_tb = 64'h2AAAAA;
    cnt = 0; prev = 1'b1;
    do begin prev = obs_en; tick(); cnt++; end while (!(prev === 1'b0 && obs_en === 1'b1) && cnt < 100);
    valid_tb = 1'b0;
    n_checks++;
    if (cnt != NA + LA + 2) begin
      n_err++;
      $display("FAIL word_period: got %0d cycles, required %0d", cnt, NA + LA + 2);
    end
    repeat (30) tick();
    ack_tb = 1'b0;
  endtask

  task automatic test_reset_mid_feed();
    logic bad;
    logic [63:0] w2;
    sel = 1'b0; coder_mode = 0;
    accept_word(64'h3C3C3C);
    repeat (10) tick();
    rstn_tb = 1'b0;
    tick();
    n_checks++;
    if (ready_a !== 1'b0 || en_a !== 1'b0 || bit_a !== 1'b0 || done_a !== 1'b0 || word_a !== '0) begin
      n_err++;
      $display("FAIL midreset_outputs: ready=%b en=%b bit=%b done=%b word=%h, required all 0",
               ready_a, en_a, bit_a, done_a, word_a);
    end
    rstn_tb = 1'b1;
    bad = 1'b0;
    repeat (40) begin tick(); if (done_a !== 1'b0) bad = 1'b1; end
    n_checks++;
    if (bad !== 1'b0) begin n_err++; $display("FAIL midreset_no_done: got bad=%b, required 0", bad); end
    w2 = {41'b0, 23'($urandom)};
    accept_word(w2);
    feed_word(w2, NA, LA, 0, "midreset_next");
    ack_word();
  endtask

  task automatic test_lat3();
    sel = 1'b1; coder_mode = 0;
    accept_word(64'hA5);
    feed_word(64'hA5, NB, LB, 0, "lat3_a5");
    ack_word();
    sel = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_err = 0;
    test_reset();
    test_known_word();
    test_faulty_coder();
    test_ack_hold();
    test_back_to_back();
    test_reset_mid_feed();
    test_lat3();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "timeout");
  end

endmodule
